// File: rtl/nibble_serial_mac_if.sv
// Streaming bus for nibble_serial_mac: nibble input side, busy flag and result beat output side.
// The master modport is the operand producer / result consumer; the slave modport is the MAC.
interface nibble_serial_mac_if #(
    parameter int NIBBLE_W = 4,
    parameter int OUT_W    = 8
);
    logic                in_valid;
    logic [NIBBLE_W-1:0] in_data;
    logic                signed_mode;
    logic                accumulate;
    logic                busy;
    logic                out_valid;
    logic [OUT_W-1:0]    out_data;

    modport master (
        output in_valid, in_data, signed_mode, accumulate,
        input  busy, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, signed_mode, accumulate,
        output busy, out_valid, out_data
    );
endinterface

// File: rtl/nibble_serial_mac.sv
// Nibble-serial multiplier / MAC: loads A then B MS nibble first, multiplies, streams the result out.
// Define NIBBLE_SERIAL_MAC_ACC_EN to build the running accumulator; otherwise the result is the bare product.
module nibble_serial_mac #(
    parameter int OPERAND_W = 16,
    parameter int NIBBLE_W  = 4,
    parameter int OUT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    nibble_serial_mac_if.slave bus
);
    localparam int IN_BEATS  = 2 * OPERAND_W / NIBBLE_W;
    localparam int OUT_BEATS = 2 * OPERAND_W / OUT_W;
    localparam int RES_W     = 2 * OPERAND_W;
    localparam int BEAT_CW   = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        DRAIN
    } state_t;

    state_t               state_q;
    logic [RES_W-1:0]     shift_q;
    logic [RES_W-1:0]     outShift_q;
    logic [BEAT_CW-1:0]   beatCnt_q;
    logic [OUT_CW-1:0]    outCnt_q;
    logic                 signed_q;
    logic                 busy_q;
    logic                 outValid_q;

    logic [OPERAND_W-1:0] opA;
    logic [OPERAND_W-1:0] opB;
    logic [RES_W-1:0]     aExt;
    logic [RES_W-1:0]     bExt;
    logic [RES_W-1:0]     product;
    logic [RES_W-1:0]     result_d;
    logic                 firstBeat;

    assign firstBeat = (state_q == LOAD) && bus.in_valid && (beatCnt_q == '0);

    // Extending both operands to RES_W makes one truncated multiply correct for signed and unsigned.
    always_comb begin
        opA     = shift_q[RES_W-1 -: OPERAND_W];
        opB     = shift_q[OPERAND_W-1:0];
        aExt    = signed_q ? {{OPERAND_W{opA[OPERAND_W-1]}}, opA} : {{OPERAND_W{1'b0}}, opA};
        bExt    = signed_q ? {{OPERAND_W{opB[OPERAND_W-1]}}, opB} : {{OPERAND_W{1'b0}}, opB};
        product = aExt * bExt;
    end

`ifdef NIBBLE_SERIAL_MAC_ACC_EN
    logic [RES_W-1:0] acc_q;
    logic             accum_q;

    assign result_d = accum_q ? (acc_q + product) : product;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            accum_q <= 1'b0;
        end else begin
            if (firstBeat)
                accum_q <= bus.accumulate;
            if (state_q == CALC)
                acc_q <= result_d;
        end
    end
`else
    logic unusedAccumulate;
    assign unusedAccumulate = bus.accumulate;
    assign result_d         = product;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            shift_q    <= '0;
            outShift_q <= '0;
            beatCnt_q  <= '0;
            outCnt_q   <= '0;
            signed_q   <= 1'b0;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        shift_q <= {shift_q[RES_W-NIBBLE_W-1:0], bus.in_data};
                        if (beatCnt_q == '0)
                            signed_q <= bus.signed_mode;
                        if (beatCnt_q == BEAT_CW'(IN_BEATS - 1)) begin
                            beatCnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end else begin
                            beatCnt_q <= beatCnt_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    outShift_q <= result_d;
                    outCnt_q   <= '0;
                    outValid_q <= 1'b1;
                    state_q    <= DRAIN;
                end
                DRAIN: begin
                    outShift_q <= outShift_q << OUT_W;
                    if (outCnt_q == OUT_CW'(OUT_BEATS - 1)) begin
                        outCnt_q   <= '0;
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        outCnt_q <= outCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= LOAD;
                    busy_q     <= 1'b0;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outValid_q ? outShift_q[RES_W-1 -: OUT_W] : '0;
endmodule
